// File: rtl/ppl_fetch_pkg.sv
// ----------------------------------------------------------------------------
// ppl_fetch_pkg
// Shared definitions for the instruction-fetch stage of the 5-stage MIPS
// pipeline:
//   - next-PC select encodings driven by decode on pcSrc
//   - fetch FSM state encoding (SEQ = normal, PEND = redirect held across a
//     memory wait)
//   - default bubble instruction word (sll $0,$0,0)
// ----------------------------------------------------------------------------
package ppl_fetch_pkg;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JR  = 2'b10;
    localparam logic [1:0] PCSRC_J   = 2'b11;

    typedef enum logic {
        ST_SEQ  = 1'b0,
        ST_PEND = 1'b1
    } fetch_state_e;

    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

endpackage : ppl_fetch_pkg

// File: rtl/ppl_fetch_mux4x32.sv
// ----------------------------------------------------------------------------
// mux4x32
// Plain 4:1 multiplexer on 32-bit words, used for next-PC selection.
// Ports:
//   in0_i..in3_i  input  32  data inputs, selected by sel_i = 0..3
//   sel_i         input  2   select
//   y_o           output 32  selected word
// ----------------------------------------------------------------------------
module mux4x32 (
    input  logic [31:0] in0_i,
    input  logic [31:0] in1_i,
    input  logic [31:0] in2_i,
    input  logic [31:0] in3_i,
    input  logic [1:0]  sel_i,
    output logic [31:0] y_o
);

    always_comb begin
        y_o = in0_i;
        unique case (sel_i)
            2'd0:    y_o = in0_i;
            2'd1:    y_o = in1_i;
            2'd2:    y_o = in2_i;
            default: y_o = in3_i;
        endcase
    end

endmodule : mux4x32

// File: rtl/ppl_fetch.sv
// ----------------------------------------------------------------------------
// ppl_fetch
// Instruction-fetch stage: holds the PC, issues instruction-memory requests
// and owns the IF/ID register (dpc4, dinst). Redirects from decode (branch,
// jr, j/jal) take effect after the architectural delay slot. A wait-stated
// memory produces NOP bubbles; a redirect seen during a wait is parked in
// pend_addr (state PEND) and applied once the delay slot has been fetched.
//
// Ports:
//   clk         input   1   clock, rising edge
//   reset       input   1   synchronous active-high reset
//   branchAddr  input  32   branch target
//   jrAddr      input  32   register-jump target
//   jalAddr     input  32   j/jal target
//   pcSrc       input   2   next-PC select (00 seq, 01 br, 10 jr, 11 j)
//   pcContinue  input   1   0 = decode stall, hold PC and IF/ID
//   imem_req    output  1   fetch request (registered)
//   imem_addr   output 32   fetch address (= PC register)
//   imem_rdata  input  32   instruction word, valid with imem_ready
//   imem_ready  input   1   same-cycle data valid
//   dpc4        output 32   IF/ID pc+4
//   dinst       output 32   IF/ID instruction
//
// Optional build macro FETCH_PERF_CNT_EN adds:
//   cnt_clr     input   1   clear bubble counter (wins over increment)
//   bubble_cnt  output 32   saturating count of NOP bubbles inserted
// ----------------------------------------------------------------------------
module ppl_fetch
    import ppl_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] branchAddr,
    input  logic [31:0] jrAddr,
    input  logic [31:0] jalAddr,
    input  logic [1:0]  pcSrc,
    input  logic        pcContinue,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
`ifdef FETCH_PERF_CNT_EN
    input  logic        cnt_clr,
    output logic [31:0] bubble_cnt,
`endif
    output logic [31:0] dpc4,
    output logic [31:0] dinst
);

    logic [31:0]  pc_q;
    logic [31:0]  pend_addr_q;
    logic [31:0]  dpc4_q;
    logic [31:0]  dinst_q;
    logic         imem_req_q;
    fetch_state_e state_q;

    logic [31:0]  pc4;
    logic [31:0]  next_pc;
    logic         fire;
    logic         bubble;

    assign pc4    = pc_q + 32'd4;   // wraps modulo 2^32
    assign fire   = imem_req_q & imem_ready;
    assign bubble = pcContinue & ~fire;

    mux4x32 u_next_pc_mux (
        .in0_i (pc4),
        .in1_i (branchAddr),
        .in2_i (jrAddr),
        .in3_i (jalAddr),
        .sel_i (pcSrc),
        .y_o   (next_pc)
    );

    // Stall (pcContinue=0) outranks everything: nothing in this block moves.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            pend_addr_q <= 32'h0000_0000;
            dpc4_q      <= RESET_PC + 32'd4;
            dinst_q     <= NOP_INST;
            imem_req_q  <= 1'b0;
            state_q     <= ST_SEQ;
        end else begin
            imem_req_q <= 1'b1;
            if (pcContinue) begin
                dpc4_q <= pc4;
                if (fire) begin
                    // Fetched word is the delay slot when a redirect is taken.
                    dinst_q <= imem_rdata;
                    if (state_q == ST_PEND) begin
                        pc_q    <= pend_addr_q;
                        state_q <= ST_SEQ;
                    end else begin
                        pc_q <= next_pc;
                    end
                end else begin
                    // PC holds so the delay slot is retried; park the redirect.
                    dinst_q <= NOP_INST;
                    if (state_q == ST_SEQ && pcSrc != PCSRC_SEQ) begin
                        pend_addr_q <= next_pc;
                        state_q     <= ST_PEND;
                    end
                end
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] bubble_cnt_q;

    always_ff @(posedge clk) begin
        if (reset || cnt_clr) begin
            bubble_cnt_q <= 32'h0000_0000;
        end else if (bubble && bubble_cnt_q != 32'hFFFF_FFFF) begin
            bubble_cnt_q <= bubble_cnt_q + 32'd1;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
`else
    logic unused_bubble;
    assign unused_bubble = bubble;
`endif

`ifndef SYNTHESIS
    // While a redirect is parked, ID holds a bubble and must not redirect.
    always_ff @(posedge clk) begin
        if (!reset && state_q == ST_PEND) begin
            assert (pcSrc == PCSRC_SEQ)
                else $error("ppl_fetch: redirect received while a redirect is pending");
        end
    end
`endif

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign dpc4      = dpc4_q;
    assign dinst     = dinst_q;

endmodule : ppl_fetch

// File: tb/tb_ppl_fetch.sv
// ----------------------------------------------------------------------------
// tb_ppl_fetch
// Directed bench for ppl_fetch. The instruction memory returns word = address.
// Inputs change on the falling edge; outputs are checked on the falling edge
// after each rising edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ppl_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] branchAddr, jrAddr, jalAddr;
    logic [1:0]  pcSrc;
    logic        pcContinue;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] dpc4, dinst;
`ifdef FETCH_PERF_CNT_EN
    logic        cnt_clr;
    logic [31:0] bubble_cnt;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr;

    ppl_fetch dut (
        .clk        (clk),
        .reset      (reset),
        .branchAddr (branchAddr),
        .jrAddr     (jrAddr),
        .jalAddr    (jalAddr),
        .pcSrc      (pcSrc),
        .pcContinue (pcContinue),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
`ifdef FETCH_PERF_CNT_EN
        .cnt_clr    (cnt_clr),
        .bubble_cnt (bubble_cnt),
`endif
        .dpc4       (dpc4),
        .dinst      (dinst)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
            else begin
                fails++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
            end
        $display("[TB] %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_if(input string tag, input logic [31:0] a, input logic [31:0] p4,
                          input logic [31:0] inst);
        chk({tag, ".addr"}, imem_addr, a);
        chk({tag, ".dpc4"}, dpc4, p4);
        chk({tag, ".dinst"}, dinst, inst);
    endtask

    initial begin
        reset      = 1'b1;
        branchAddr = 32'h0;
        jrAddr     = 32'h0;
        jalAddr    = 32'h0;
        pcSrc      = 2'b00;
        pcContinue = 1'b1;
        imem_ready = 1'b1;
`ifdef FETCH_PERF_CNT_EN
        cnt_clr    = 1'b0;
`endif
        // Reset state
        tick();
        chk("rst.req", {31'd0, imem_req}, 32'd0);
        chk_if("rst", 32'h0, 32'h4, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst.bcnt", bubble_cnt, 32'd0);
`endif
        // 1. Sequential fetch; first cycle out of reset has no request -> bubble
        reset = 1'b0;
        tick();
        chk("seq0.req", {31'd0, imem_req}, 32'd1);
        chk_if("seq0", 32'h0, 32'h4, 32'h0);
        tick();
        chk_if("seq1", 32'h4, 32'h4, 32'h0);
        tick();
        chk_if("seq2", 32'h8, 32'h8, 32'h4);

        // 2. Branch at PC=8 to 0x40; word@8 is the delay slot
        pcSrc = 2'b01; branchAddr = 32'h40;
        tick();
        chk_if("br", 32'h40, 32'hC, 32'h8);
        pcSrc = 2'b00; branchAddr = 32'h0;
        tick();
        chk_if("br+1", 32'h44, 32'h44, 32'h40);

        // 3. jr to 0x100 while memory waits 3 cycles
        pcSrc = 2'b10; jrAddr = 32'h100; imem_ready = 1'b0;
        tick();
        chk_if("wait0", 32'h44, 32'h48, 32'h0);
        pcSrc = 2'b00;
        tick();
        chk_if("wait1", 32'h44, 32'h48, 32'h0);
        tick();
        chk_if("wait2", 32'h44, 32'h48, 32'h0);
        imem_ready = 1'b1;
        tick();
        chk_if("pend.ds", 32'h100, 32'h48, 32'h44);
        tick();
        chk_if("jr+1", 32'h104, 32'h104, 32'h100);

        // 4. Decode stall two cycles; redirect inputs must be ignored
        pcContinue = 1'b0; pcSrc = 2'b01; branchAddr = 32'h40;
        tick();
        chk_if("stall0", 32'h104, 32'h104, 32'h100);
        tick();
        chk_if("stall1", 32'h104, 32'h104, 32'h100);
        pcContinue = 1'b1; pcSrc = 2'b00;
        tick();
        chk_if("resume", 32'h108, 32'h108, 32'h104);

        // 5. Enter PEND with pend_addr=0x200, then reset
        pcSrc = 2'b11; jalAddr = 32'h200; imem_ready = 1'b0;
        tick();
        chk_if("pend200", 32'h108, 32'h10C, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("bcnt5", bubble_cnt, 32'd5);
`endif
        pcSrc = 2'b00; reset = 1'b1; imem_ready = 1'b1;
        tick();
        chk("prst.req", {31'd0, imem_req}, 32'd0);
        chk_if("prst", 32'h0, 32'h4, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("prst.bcnt", bubble_cnt, 32'd0);
`endif
        reset = 1'b0;
        tick();
        chk_if("prst+1", 32'h0, 32'h4, 32'h0);
        tick();
        chk_if("prst+2", 32'h4, 32'h4, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("prst.bcnt1", bubble_cnt, 32'd1);
        // Clear on a bubble cycle wins over the increment
        imem_ready = 1'b0; cnt_clr = 1'b1;
        tick();
        chk("clr.bcnt", bubble_cnt, 32'd0);
        cnt_clr = 1'b0;
        tick();
        chk("clr+1.bcnt", bubble_cnt, 32'd1);
        chk_if("clr+1", 32'h4, 32'h8, 32'h0);
        imem_ready = 1'b1;
`endif

        // 6. PC wrap from 0xFFFF_FFFC
        pcSrc = 2'b11; jalAddr = 32'hFFFF_FFFC;
        tick();
        chk_if("wrapj", 32'hFFFF_FFFC, 32'h8, 32'h4);
        pcSrc = 2'b00;
        tick();
        chk_if("wrap", 32'h0, 32'h0, 32'hFFFF_FFFC);
        tick();
        chk_if("wrap+1", 32'h4, 32'h4, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_ppl_fetch
